// File: rtl/fp_pkg.sv
// Shared float31 types and helpers for the inverse-sqrt Newton iteration datapath.
// Used by the subtract stage and the multiply stage.
package fp_pkg;

    typedef struct packed {
        logic [7:0]  exp;
        logic [22:0] frac;
    } float31_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_SPECIAL
    } fp_class_e;

    localparam int          EXP_BIAS   = 127;
    localparam int          EXP_MAX    = 255;
    localparam logic [30:0] QNAN       = 31'h7FC00000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

    // Denormals (exp=0) are flushed, so the exponent alone decides the class.
    function automatic fp_class_e classify(input logic [7:0] exp);
        if (exp == 8'd0)
            return FP_ZERO;
        if (exp == 8'(EXP_MAX))
            return FP_SPECIAL;
        return FP_NORMAL;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalize, round and pack for a 48-bit mantissa product.
// Applies special/zero/overflow/underflow precedence and reports the local error.
module fp_norm_round #(
    parameter int          ROUND_MODE = 0,
    parameter logic [30:0] MAX_FINITE = 31'h7F7FFFFF,
    parameter logic [30:0] QNAN       = 31'h7FC00000
) (
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    input  logic              special,
    input  logic              zero,
    output logic [30:0]       result,
    output logic              error
);
    import fp_pkg::*;

    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_n;

    always_comb begin
        // NOTE: every output of this block gets a value up front so no path can infer a latch.
        mant     = prod[45:23];
        guard    = prod[22];
        sticky   = |prod[21:0];
        exp_n    = exp_in;
        result   = '0;
        error    = 1'b0;

        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_in + 10'sd1;
        end

        round_up = (ROUND_MODE == 1) && guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + 24'(round_up);
        // All-ones mantissa rounding up becomes 1.0 x 2: fraction bits are already zero.
        if (mant_r[23])
            exp_n = exp_n + 10'sd1;

        if (special) begin
            result = QNAN;
            error  = 1'b1;
        end else if (zero) begin
            result = '0;
            error  = 1'b0;
        end else if (int'(exp_n) >= EXP_MAX) begin
            result = MAX_FINITE;
            error  = 1'b1;
        end else if (int'(exp_n) <= 0) begin
            result = '0;
            error  = 1'b1;
        end else begin
            result = {exp_n[7:0], mant_r[22:0]};
            error  = 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_nr_pipe.sv
// Three-stage positive float31 multiplier computing y*(1.5 - x) in the Newton step.
// A single global stall freezes every stage while the output is held.
module fp_mul_nr_pipe #(
    parameter int          ROUND_MODE = 0,
    parameter logic [30:0] MAX_FINITE = 31'h7F7FFFFF,
    parameter logic [30:0] QNAN       = 31'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_a,
    input  logic [30:0] in_b,
    input  logic        in_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_product,
    output logic        out_error
);
    import fp_pkg::*;

    logic              stall;
    float31_t          fa, fb;
    fp_class_e         ca, cb;
    logic signed [9:0] exp_sum;

    logic              s1_valid, s1_error, s1_special, s1_zero;
    logic [23:0]       s1_ma, s1_mb;
    logic signed [9:0] s1_exp;

    logic              s2_valid, s2_error, s2_special, s2_zero;
    logic [47:0]       s2_prod;
    logic signed [9:0] s2_exp;

    logic [30:0]       nr_result;
    logic              nr_error;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign fa      = float31_t'(in_a);
    assign fb      = float31_t'(in_b);
    assign ca      = classify(fa.exp);
    assign cb      = classify(fb.exp);
    assign exp_sum = 10'(fa.exp) + 10'(fb.exp) - 10'(EXP_BIAS);

    // Valid bits and the visible outputs are the only architected state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_error   <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_product <= nr_result;
                out_error   <= s2_error | nr_error;
            end
        end
    end

    // NOTE: pipeline payload is left unreset; it is only ever observed alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_error   <= in_error;
            s1_special <= (ca == FP_SPECIAL) | (cb == FP_SPECIAL);
            s1_zero    <= (ca == FP_ZERO) | (cb == FP_ZERO);
            s1_ma      <= {1'b1, fa.frac};
            s1_mb      <= {1'b1, fb.frac};
            s1_exp     <= exp_sum;

            s2_error   <= s1_error;
            s2_special <= s1_special;
            s2_zero    <= s1_zero;
            s2_prod    <= 48'(s1_ma) * 48'(s1_mb);
            s2_exp     <= s1_exp;
        end
    end

    fp_norm_round #(
        .ROUND_MODE (ROUND_MODE),
        .MAX_FINITE (MAX_FINITE),
        .QNAN       (QNAN)
    ) u_norm_round (
        .prod    (s2_prod),
        .exp_in  (s2_exp),
        .special (s2_special),
        .zero    (s2_zero),
        .result  (nr_result),
        .error   (nr_error)
    );

endmodule

// File: doc/fp_mul_nr_pipe.md
Name: fp_mul_nr_pipe

Overview:
- Pipelined positive-float multiplier: out = a × b, with a and b as 31-bit IEEE-754 single-precision values (sign bit implied 0).
- Sits downstream of the 1.5 − x subtract stage in the inverse-sqrt Newton iteration.
- Consumes that stage's result (a) and its delayed y operand (b), producing y·(1.5 − x).
- Receives the same valid/ready/error-flag stream the subtract stage transmits.

Parameters:
- ROUND_MODE, 0, 0 = truncate toward zero, 1 = round-to-nearest-even.
- MAX_FINITE, 31'h7F7FFFFF, saturation value on overflow.
- QNAN, 31'h7FC00000, output for Inf/NaN operands.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  31  operand a (exp[30:23], frac[22:0]).
- in_b  in  31  operand b.
- in_error  in  1  upstream error flag travelling with the beat.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_product  out  31  result.
- out_error  out  1  in_error OR error raised in this block, aligned with out_product.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, out_product=0, out_error=0; in_ready=1 the cycle after rst deasserts. Reset asserted mid-stream discards all in-flight beats; nothing emerges afterwards.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - A beat transfers when in_valid & in_ready.
  - When stall is high, all three stages hold their contents; out_product and out_error stay stable.
  - No beat is dropped or duplicated.
- Latency: exactly 3 cycles from accepted input to out_valid when there is no stall. Throughput is 1 beat per cycle. Bubbles propagate as valid=0.
- Stage 1, unpack:
  - Classify each operand as zero (exp=0, denormals flushed), special (exp=255), or normal.
  - Mantissa = {1, frac} (24 bits).
  - Exponent sum = ea + eb − 127, 10-bit signed.
- Stage 2, multiply: 24×24 → 48-bit product. Special flags and error flags are carried along.
- Stage 3, normalize, round and pack:
  - If p[47]=1, take mantissa bits [46:24] and add 1 to the exponent; otherwise take [45:23].
  - ROUND_MODE=1 uses guard bit plus sticky bit with ties-to-even. A mantissa carry-out renormalizes and increments the exponent.
- Result precedence (checked in this order):
  - (1) Any special operand → QNAN, error=1.
  - (2) Any zero operand → 0, error=0.
  - (3) Final exponent ≥255 → MAX_FINITE, error=1.
  - (4) Final exponent ≤0 → 0, error=1 (underflow flush).
  - (5) Otherwise normal result.
- out_error = in_error of that beat OR the local error. The flag is never sticky across beats.
- Simultaneous accept and output in the same cycle is legal when out_ready=1.

Decomposition:
- Shared package fp_pkg holds:
  - float31_t struct (exp[7:0], frac[22:0]);
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN, MAX_FINITE;
  - classify function (zero/special/normal).
  - The subtract stage reuses this package.
- One sub-module, fp_norm_round: combinational stage-3 normalize/round/pack, parameterized by ROUND_MODE.

Test Plan:
- Basic multiplies:
  - 0x3FC00000 × 0x40000000 → 0x40400000 (3.0), error=0, out_valid exactly 3 cycles after accept.
  - 0x3F800000 × 0x3FC00000 → 0x3FC00000.
- Rounding: 0x3FC00001 × 0x3FC00001 → 0x40100001 with ROUND_MODE=0; 0x40100002 with ROUND_MODE=1.
- Boundaries:
  - 0x7F000000 × 0x40000000 → 0x7F7FFFFF, error=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, error=1.
  - 0x7F800000 × 0x3F800000 → 0x7FC00000, error=1.
  - 0x00000000 × 0x7F000000 → 0, error=0.
- Backpressure: stream 8 back-to-back beats; drop out_ready for 5 cycles after the first output appears → in_ready low during those cycles, out_product held stable, all 8 results emerge in order, none lost or duplicated.
- Error propagation: in_error=1 on the 3rd beat only → out_error=1 on the 3rd output only, value still correct.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid=0 the next cycle, no stale outputs; a fresh beat 1.0 × 1.0 → 0x3F800000 after 3 cycles.
